tx_link_sequencer: RTL and testbench
====================================

# tx_link_sequencer

Link bring-up sequencer and word scheduler for the serializer TX path. Runs in the 16-bit word clock domain (the divided PRBS-generator clock) and produces the 16-bit parallel word that feeds the 16:4/4:1 mux chain. It steps through a fixed sequence: upstream pattern-generator reset, training pattern, sync word, then live data through a valid/ready handshake. In data mode it adds fill-word substitution on underflow and single-word error injection for BER testing.

## Interface
Parameters:
- N_HOLD, 16: cycles spent in HOLD with `prbs_rst` asserted. Must be ≥1.
- N_TRAIN, 64: cycles spent sending TRAIN_WORD. Must be ≥1.
- TRAIN_WORD, 16'hAAAA: training pattern word.
- SYNC_WORD, 16'hB38F: one-cycle alignment marker.
- FILL_WORD, 16'h0000: word sent in DATA when no input is valid.

Ports:
- clk  in  1  word clock. All logic is rising-edge.
- rst  in  1  asynchronous, active-high reset. Resets every register immediately.
- en  in  1  level enable. When low, the block returns to IDLE.
- restart  in  1  single-cycle pulse. Re-runs the sequence from HOLD.
- data_in  in  16  payload word.
- data_valid  in  1  payload valid.
- data_ready  out  1  high exactly when state==DATA.
- inj_error  in  1  single-cycle pulse. Corrupts the next DATA word.
- din  out  16  registered word to the serializer.
- prbs_rst  out  1  reset for the upstream pattern generators.
- link_up  out  1  high when state==DATA.
- state  out  3  IDLE=0, HOLD=1, TRAIN=2, SYNC=3, DATA=4.
- underflow_cnt  out  8  saturating count of DATA cycles with no valid input.

## Operation
- States and transitions:
  - IDLE: `en`=1 → HOLD.
  - HOLD: after N_HOLD cycles → TRAIN.
  - TRAIN: after N_TRAIN cycles → SYNC.
  - SYNC: after 1 cycle → DATA.
  - DATA: stays in DATA.
- Any state with `en`=0 → IDLE on the next edge.
- Any state except IDLE with `restart`=1 and `en`=1 → HOLD. This reloads the counter and clears `underflow_cnt`.
- If `en`=0 and `restart`=1 in the same cycle, `en` wins and the next state is IDLE.
- `restart` in IDLE is ignored unless `en`=1; in that case it behaves as a normal HOLD entry.
- Outputs by state:
  - `prbs_rst` is 1 in IDLE and HOLD, 0 otherwise.
  - `din` is 0 in IDLE and HOLD, TRAIN_WORD in TRAIN, SYNC_WORD in SYNC.
- DATA word selection, applied at each edge where the current state is DATA and the next state is DATA:
  - `din` <= (`data_valid` ? `data_in` : FILL_WORD) ^ {15'b0, err_pend}.
- Error injection:
  - An `inj_error` pulse sampled in DATA sets `err_pend`.
  - `err_pend` applies to exactly one word: the next word loaded, including the word loaded on the same edge if `inj_error` arrives then. It clears when consumed.
  - `inj_error` sampled in any other state is dropped.
  - A second pulse while `err_pend` is set is absorbed; there is no queueing.
- Underflow: a DATA-state edge with `data_valid`=0 increments `underflow_cnt`, saturating at 255.
- Counter: a single down-counter of width $clog2(max(N_HOLD,N_TRAIN))+1, loaded on HOLD and TRAIN entry.

## Timing
- Reset values:
  - `state`=IDLE, `din`=16'h0000, `prbs_rst`=1.
  - `data_ready`=0, `link_up`=0, `underflow_cnt`=0.
  - `err_pend`=0, counter=0.
- `din` and `state` update on the same edge, so `din` always reflects the current state.
- Sequence length: with `en` sampled high at edge E0:
  - HOLD covers cycles E0..E0+N_HOLD-1.
  - TRAIN covers cycles E0+N_HOLD onward for N_TRAIN cycles.
  - SYNC is at E0+N_HOLD+N_TRAIN.
  - DATA is entered at edge E0+N_HOLD+N_TRAIN+1 with `din`=FILL_WORD.
- Handshake: a word is accepted at an edge where `data_valid`&&`data_ready`. It appears on `din` for the cycle immediately after that edge, giving 1-cycle latency. There is no back-pressure inside DATA.
- `data_ready` and `link_up` are decoded from the state register only. They have no combinational path from inputs.
- Reset asserted mid-sequence forces all reset values asynchronously. After reset is released, the block waits in IDLE for `en`.

## Test plan
- Reset then `en`=1, N_HOLD=16, N_TRAIN=64 → `prbs_rst` high for 16 cycles, then exactly 64 words of 16'hAAAA, then one 16'hB38F, then `link_up`=1 and `din`=16'h0000.
- In DATA, stream `data_in`=16'h0001..16'h0010 with `valid` held high → `din` shows the same 16 words in order, each 1 cycle after acceptance. `underflow_cnt` stays 0.
- In DATA, drop `valid` for 300 cycles → `din`=FILL_WORD throughout and `underflow_cnt` saturates at 255.
- In DATA, `data_in`=16'h1234 with `valid` high and a 1-cycle `inj_error` → next `din`=16'h1235, following word clean. `inj_error` pulsed in TRAIN → no corruption.
- `restart` pulse mid-DATA → `link_up` falls on the next edge, the full HOLD/TRAIN/SYNC sequence repeats, and `underflow_cnt` reads 0. `restart` and `en`=0 in the same cycle → IDLE.
- Assert `rst` during TRAIN → all outputs take their reset values immediately. `en` held high after release → the sequence restarts from HOLD.

Source files
------------

// File: rtl/tx_link_sequencer.sv
// TX link bring-up sequencer: HOLD/TRAIN/SYNC preamble, then registered data words (1-cycle latency).
// data_ready is high for all of DATA; no back-pressure there, underflow sends FILL_WORD.
module tx_link_sequencer #(
    parameter int          N_HOLD     = 16,
    parameter int          N_TRAIN    = 64,
    parameter logic [15:0] TRAIN_WORD = 16'hAAAA,
    parameter logic [15:0] SYNC_WORD  = 16'hB38F,
    parameter logic [15:0] FILL_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        inj_error,
    output logic [15:0] din,
    output logic        prbs_rst,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [7:0]  underflow_cnt
);

    localparam int N_MAX = (N_HOLD > N_TRAIN) ? N_HOLD : N_TRAIN;
    localparam int CW    = $clog2(N_MAX) + 1;
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(N_HOLD - 1);
    localparam logic [CW-1:0] TRAIN_LOAD = CW'(N_TRAIN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        TRAIN = 3'd2,
        SYNC  = 3'd3,
        DATA  = 3'd4
    } state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   din_nxt;
    logic [7:0]    uf_nxt;
    logic          err_pend, err_pend_nxt;
    logic          err_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt           <= '0;
            din           <= 16'h0000;
            underflow_cnt <= 8'd0;
            err_pend      <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt           <= cnt_nxt;
            din           <= din_nxt;
            underflow_cnt <= uf_nxt;
            err_pend      <= err_pend_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt;
        din_nxt      = 16'h0000;
        uf_nxt       = underflow_cnt;
        err_pend_nxt = err_pend;
        err_now      = err_pend | inj_error;

        if (state_q == DATA && !data_valid && underflow_cnt != 8'hFF)
            uf_nxt = underflow_cnt + 8'd1;

        // en dominates restart; restart from IDLE is just a normal start
        if (!en) begin
            state_nxt = IDLE;
        end else if (restart && state_q != IDLE) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LOAD;
            uf_nxt    = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = TRAIN;
                        cnt_nxt   = TRAIN_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                TRAIN: begin
                    if (cnt == '0) state_nxt = SYNC;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                SYNC:    state_nxt = DATA;
                DATA:    state_nxt = DATA;
                default: state_nxt = IDLE;
            endcase
        end

        // din is loaded from the next state so it always matches the state register
        case (state_nxt)
            TRAIN: din_nxt = TRAIN_WORD;
            SYNC:  din_nxt = SYNC_WORD;
            DATA: begin
                if (state_q == DATA)
                    din_nxt = (data_valid ? data_in : FILL_WORD) ^ {15'b0, err_now};
                else
                    din_nxt = FILL_WORD;
            end
            default: din_nxt = 16'h0000;
        endcase

        if (state_q == DATA && state_nxt == DATA)
            err_pend_nxt = 1'b0;
        else
            err_pend_nxt = err_pend & (state_nxt == DATA);
    end

    assign state      = state_q;
    assign prbs_rst   = (state_q == IDLE) || (state_q == HOLD);
    assign link_up    = (state_q == DATA);
    assign data_ready = (state_q == DATA);

endmodule

// File: tb/tb_tx_link_sequencer.sv
// Scoreboard bench for tx_link_sequencer against a cycle-count reference model.
module tb_tx_link_sequencer;

    localparam int          NH    = 16;
    localparam int          NT    = 64;
    localparam logic [15:0] TW    = 16'hAAAA;
    localparam logic [15:0] SW    = 16'hB38F;
    localparam logic [15:0] FW    = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        restart;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        inj_error;
    logic [15:0] din;
    logic        prbs_rst;
    logic        link_up;
    logic [2:0]  state;
    logic [7:0]  underflow_cnt;

    tx_link_sequencer #(
        .N_HOLD(NH), .N_TRAIN(NT), .TRAIN_WORD(TW), .SYNC_WORD(SW), .FILL_WORD(FW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .inj_error(inj_error), .din(din), .prbs_rst(prbs_rst), .link_up(link_up),
        .state(state), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] d;
        logic        pr;
        logic        lk;
        logic [7:0]  uf;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model: sequence position counted from the enabling edge
    bit m_active = 0;
    int m_t      = 0;
    int m_uf     = 0;

    function automatic logic [2:0] m_state();
        if (!m_active)          return 3'd0;
        if (m_t < NH)           return 3'd1;
        if (m_t < NH + NT)      return 3'd2;
        if (m_t == NH + NT)     return 3'd3;
        return 3'd4;
    endfunction

    task automatic model_step(input logic e, input logic r, input logic v,
                              input logic [15:0] dat, input logic inj);
        logic [2:0]  cs, ns;
        logic [15:0] d;
        exp_t        x;
        cs = m_state();
        d  = 16'h0000;
        if (cs == 3'd4 && !v && m_uf < 255) m_uf = m_uf + 1;
        if (!e) begin
            m_active = 0;
            m_t      = 0;
        end else if (r && cs != 3'd0) begin
            m_t  = 0;
            m_uf = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_t      = 0;
        end else begin
            m_t = m_t + 1;
        end
        ns = m_state();
        if (ns == 3'd2)      d = TW;
        else if (ns == 3'd3) d = SW;
        else if (ns == 3'd4) d = (cs == 3'd4) ? ((v ? dat : FW) ^ {15'b0, inj}) : FW;
        x.st = ns;
        x.d  = d;
        x.pr = (ns <= 3'd1);
        x.lk = (ns == 3'd4);
        x.uf = m_uf[7:0];
        q.push_back(x);
    endtask

    task automatic step(input logic e, input logic r, input logic v,
                        input logic [15:0] dat, input logic inj);
        @(negedge clk);
        rst        = 1'b0;
        en         = e;
        restart    = r;
        data_valid = v;
        data_in    = dat;
        inj_error  = inj;
        model_step(e, r, v, dat, inj);
    endtask

    task automatic rand_step(input logic e);
        step(e, 1'b0, ($urandom_range(0, 3) != 0), 16'($urandom),
             ($urandom_range(0, 7) == 0));
    endtask

    task automatic check_reset(input string name);
        logic [29:0] act, req;
        act = {state, din, prbs_rst, data_ready, link_up, underflow_cnt};
        req = {3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got state=%0d din=%h prbs=%b rdy=%b link=%b uf=%0d, want reset values",
                     name, state, din, prbs_rst, data_ready, link_up, underflow_cnt);
        end
    endtask

    task automatic rst_step(input logic e);
        exp_t x;
        @(negedge clk);
        rst     = 1'b1;
        en      = e;
        restart = 1'b0;
        #1;
        check_reset("async_reset");
        m_active = 0;
        m_t      = 0;
        m_uf     = 0;
        x.st = 3'd0; x.d = 16'h0000; x.pr = 1'b1; x.lk = 1'b0; x.uf = 8'd0;
        q.push_back(x);
    endtask

    // monitor: one output word per cycle, compared after the edge settles
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (state !== e.st || din !== e.d || prbs_rst !== e.pr ||
                    link_up !== e.lk || data_ready !== e.lk || underflow_cnt !== e.uf) begin
                    n_bad++;
                    $display("FAIL word@%0t: got st=%0d din=%h prbs=%b link=%b rdy=%b uf=%0d, want st=%0d din=%h prbs=%b link=%b uf=%0d",
                             $time, state, din, prbs_rst, link_up, data_ready, underflow_cnt,
                             e.st, e.d, e.pr, e.lk, e.uf);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; restart = 1'b0;
        data_in = 16'h0; data_valid = 1'b0; inj_error = 1'b0;
        #1;
        check_reset("reset_init");
        rst_step(1'b0);
        repeat (3) rand_step(1'b0);

        // bring-up with inj_error pulses landing in HOLD/TRAIN
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 85; i++) rand_step(1'b1);

        for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 1'b1, 16'(k), 1'b0);
        for (int i = 0; i < 120; i++) rand_step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h5678, 1'b0);
        for (int i = 0; i < 10; i++) rand_step(1'b1);

        // restart mid-DATA, then restart with en low
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 90; i++) rand_step(1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h4321, 1'b0);
        repeat (3) rand_step(1'b0);

        // reset during TRAIN with en held high
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 40; i++) rand_step(1'b1);
        rst_step(1'b1);
        rst_step(1'b1);
        for (int i = 0; i < 90; i++) rand_step(1'b1);

        @(posedge clk);
        #5;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected words left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
